alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
- Shares one ALU32Bit instance between two requesters (port 0, port 1), e.g. an execute stage and a multi-cycle helper unit.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration selects a requester. Operands and opcode are captured into registers, the ALU evaluates them, and the result is held until the owner accepts it.
- Also reports illegal-opcode errors and counts completed operations.

Parameters:
- CNT_W, 16, width of the per-port completed-operation counters.

Ports:
- Clk  in  1  clock; all registers update on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 has a request.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_ctl  in  4  port 0 ALUControl code.
- req0_a  in  32  port 0 operand A.
- req0_b  in  32  port 0 operand B.
- rsp0_valid  out  1  port 0 result available.
- rsp0_ready  in  1  port 0 accepts the result.
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b, rsp1_valid, rsp1_ready: same as port 0, for port 1.
- rsp_result  out  32  registered ALU result; shared by both ports and qualified by rspN_valid.
- rsp_zero  out  1  registered Zero flag.
- rsp_err  out  1  set when the captured opcode is 4'b1000 (unused code).
- busy  out  1  high whenever state is not IDLE.
- done_cnt0  out  CNT_W  number of completed port 0 responses.
- done_cnt1  out  CNT_W  number of completed port 1 responses.

Behaviour:
- Reset: state=IDLE; rr_ptr=0 (port 0 preferred). The following are all 0: reqN_ready, rspN_valid, rsp_result, rsp_zero, rsp_err, busy, done_cnt0, done_cnt1, captured op registers, owner.
- Reset mid-operation: the in-flight operation is abandoned with no response and no counter increment.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant is combinational.
  - Only one valid: grant that port.
  - Both valid: grant port rr_ptr.
  - req_ready of the granted port only = 1; the other port's req_ready = 0.
  - On valid&ready: capture ctl, A, B and owner; go to EXEC.
  - No valid: stay in IDLE, both ready = 0.
- EXEC (exactly 1 cycle):
  - The ALU is driven from the captured registers only.
  - At the clock edge:
    - rsp_result <= ALUResult;
    - rsp_zero <= Zero;
    - rsp_err <= (ctl==4'b1000);
    - rsp_valid of the owner <= 1;
    - rr_ptr <= ~owner;
    - go to RESP.
- RESP:
  - The owner's rsp_valid is held high; rsp_result, rsp_zero and rsp_err are held stable.
  - Both req_ready = 0.
  - On rsp_ready of the owner: drop rsp_valid, increment the owner's done_cnt, go to IDLE.
  - The other port's rsp_ready is ignored.
- Latency and throughput:
  - Request accept edge to rsp_valid high = 2 clock edges (accept→EXEC, EXEC→RESP).
  - Minimum issue interval = 3 cycles (IDLE, EXEC, RESP with immediate accept).
- Opcode set passed to the ALU:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 NOR, 0100 XOR, 0101 sign-extend (B=0 byte, B=1 half), 0110 SUB.
  - 0111 SLT (signed), 1001 MUL (low 32 bits), 1010 SLL, 1011 SGT (signed), 1100 CLZ.
  - 1101 SRL / ROTR (B[5]=1 selects rotate, amount B[4:0]), 1110 SLTU, 1111 SRA.
  - 1000 is illegal: result 0, zero 1, rsp_err 1. It still completes normally and still counts.
- Arithmetic: ADD, SUB and MUL wrap modulo 2^32. There are no overflow flags.
- Requester rule: ctl, A and B must stay stable while valid=1 and ready=0. A requester may drop valid before it is granted; no capture occurs in that case.
- done_cnt wraps at 2^CNT_W-1 → 0.
- Simultaneous events:
  - A new request that arrives in EXEC or RESP waits; it is not lost, provided valid is held.
  - rsp_ready asserted in EXEC has no effect.
  - rsp_valid and req_ready are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Single op: port 0 sends ADD, A=5, B=7 → req0_ready=1 in the same cycle; rsp0_valid rises 2 edges later; rsp_result=12, rsp_zero=0, rsp_err=0; done_cnt0=1 after accept.
- Contention: both ports hold valid continuously (p0 SUB 9-9, p1 SLT A=-1, B=1) → grants alternate p0, p1, p0, p1.
  - p0 returns result=0, zero=1.
  - p1 returns result=1.
  - Each issue is 3 cycles apart with immediate rsp_ready.
- Backpressure: port 1 MUL 0x10000 × 0x10000 with rsp1_ready held low for 5 cycles → result 0 (wrap) and zero=1 held stable; req0 stays not ready throughout; completes on the cycle rsp1_ready=1.
- Shift/rotate: SRL A=0x80000001, B=1 → 0x40000000; ROTR with B=0x21 → 0xC0000000; CLZ A=0x00010000 → 15; SRA A=0x80000000, B=4 → 0xF8000000.
- Illegal opcode: ctl=1000 → rsp_result=0, rsp_zero=1, rsp_err=1; done_cnt increments.
- Reset mid-op: assert Reset asynchronously during EXEC → all outputs 0 immediately; no rsp_valid after release; rr_ptr=0, so port 0 wins the next simultaneous request.

Source files
------------

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin sharing of one 32-bit ALU between two valid/ready ports
// Revision : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_ctl,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_ctl,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt0,
   output logic [CNT_W-1:0] done_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_ILLEGAL = 4'b1000;

   state_t            state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic              owner_q, owner_d;
   logic [3:0]        ctl_q, ctl_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp0_valid_q, rsp0_valid_d;
   logic              rsp1_valid_q, rsp1_valid_d;
   logic [CNT_W-1:0]  done_cnt0_q, done_cnt0_d;
   logic [CNT_W-1:0]  done_cnt1_q, done_cnt1_d;

   logic              grant_valid;
   logic              grant_port;
   logic              owner_rsp_ready;
   logic [31:0]       alu_result;
   logic              alu_zero;
   logic [4:0]        shamt;
   logic [5:0]        clz;

   // Grant is combinational in IDLE; suppressed while reset is held so ready reads 0
   always_comb begin
      grant_valid = 1'b0;
      grant_port  = 1'b0;
      if ((state_q == IDLE) && !Reset) begin
         if (req0_valid && req1_valid) begin
            grant_valid = 1'b1;
            grant_port  = rr_ptr_q;
         end else if (req0_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
         end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
         end
      end
   end

   assign req0_ready      = grant_valid && !grant_port;
   assign req1_ready      = grant_valid &&  grant_port;
   assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

   // Shared ALU, fed only from the captured operand registers
   assign shamt = b_q[4:0];

   always_comb begin
      clz = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (a_q[i]) begin
            clz = 6'(31 - i);
         end
      end
   end

   always_comb begin
      alu_result = 32'd0;
      case (ctl_q)
         4'b0000: alu_result = a_q & b_q;
         4'b0001: alu_result = a_q | b_q;
         4'b0010: alu_result = a_q + b_q;
         4'b0011: alu_result = ~(a_q | b_q);
         4'b0100: alu_result = a_q ^ b_q;
         4'b0101: alu_result = b_q[0] ? {{16{a_q[15]}}, a_q[15:0]}
                                      : {{24{a_q[7]}},  a_q[7:0]};
         4'b0110: alu_result = a_q - b_q;
         4'b0111: alu_result = {31'd0, ($signed(a_q) < $signed(b_q))};
         4'b1001: alu_result = a_q * b_q;
         4'b1010: alu_result = a_q << shamt;
         4'b1011: alu_result = {31'd0, ($signed(a_q) > $signed(b_q))};
         4'b1100: alu_result = {26'd0, clz};
         4'b1101: begin
            // b[5] turns the logical right shift into a rotate
            if (b_q[5]) begin
               alu_result = (a_q >> shamt) | (a_q << (6'd32 - {1'b0, shamt}));
            end else begin
               alu_result = a_q >> shamt;
            end
         end
         4'b1110: alu_result = {31'd0, (a_q < b_q)};
         4'b1111: alu_result = $signed(a_q) >>> shamt;
         default: alu_result = 32'd0;
      endcase
   end

   assign alu_zero = (alu_result == 32'd0);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      ctl_d        = ctl_q;
      a_d          = a_q;
      b_d          = b_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      done_cnt0_d  = done_cnt0_q;
      done_cnt1_d  = done_cnt1_q;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_port;
               ctl_d   = grant_port ? req1_ctl : req0_ctl;
               a_d     = grant_port ? req1_a   : req0_a;
               b_d     = grant_port ? req1_b   : req0_b;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = (ctl_q == OP_ILLEGAL);
            rsp0_valid_d = !owner_q;
            rsp1_valid_d = owner_q;
            rr_ptr_d     = !owner_q;
            state_d      = RESP;
         end
         RESP: begin
            if (owner_rsp_ready) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               if (owner_q) begin
                  done_cnt1_d = done_cnt1_q + CNT_W'(1);
               end else begin
                  done_cnt0_d = done_cnt0_q + CNT_W'(1);
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         owner_q      <= 1'b0;
         ctl_q        <= 4'd0;
         a_q          <= 32'd0;
         b_q          <= 32'd0;
         rsp_result_q <= 32'd0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         done_cnt0_q  <= '0;
         done_cnt1_q  <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         ctl_q        <= ctl_d;
         a_q          <= a_d;
         b_q          <= b_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         done_cnt0_q  <= done_cnt0_d;
         done_cnt1_q  <= done_cnt1_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_err    = rsp_err_q;
   assign busy       = (state_q != IDLE);
   assign done_cnt0  = done_cnt0_q;
   assign done_cnt1  = done_cnt1_q;

endmodule
`default_nettype wire
